// File: rtl/uart_tx_hexfmt.sv
// uart_tx_hexfmt
//   Formatter stage sitting directly upstream of uart_tx. Takes binary words
//   over a stb/rdy handshake and emits them as ASCII hex characters, MSB
//   nibble first, followed by a separator. Characters go one per cycle into
//   the uart_tx FIFO push interface (push/data/full).
//
//   Build option: define UART_TX_HEXFMT_CRLF_EN to terminate each word with
//   CR LF (0x0D 0x0A). Left undefined, each word ends with a single space
//   (0x20) and the SEP1 state is not built.
//
// Parameters
//   DATAWIDTH  input word width, multiple of 4, 4..64
//   HEXUPPER   1: digits A-F, 0: digits a-f
//
// Ports
//   clk_i    clock (shared with the uart_tx push side)
//   rst_i    synchronous active-high reset
//   stb_i    word valid; only taken while rdy_o=1
//   data_i   word to format
//   rdy_o    block can accept a word
//   busy_o   word in progress
//   push_o   to uart_tx push_i (combinational, = busy & !full & !rst)
//   data_o   ASCII character, to uart_tx data_i
//   full_i   from uart_tx full_o
module uart_tx_hexfmt #(
  parameter int DATAWIDTH = 32,
  parameter bit HEXUPPER  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stb_i,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic                 rdy_o,
  output logic                 busy_o,
  output logic                 push_o,
  output logic [7:0]           data_o,
  input  logic                 full_i
);

  localparam int NIB = DATAWIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(NIB - 1);

`ifdef UART_TX_HEXFMT_CRLF_EN
  localparam logic [7:0] SEP0_CH = 8'h0D;
  localparam logic [7:0] SEP1_CH = 8'h0A;
  typedef enum logic [1:0] {IDLE = 2'd0, HEX = 2'd1, SEP0 = 2'd2, SEP1 = 2'd3} state_t;
`else
  localparam logic [7:0] SEP0_CH = 8'h20;
  typedef enum logic [1:0] {IDLE = 2'd0, HEX = 2'd1, SEP0 = 2'd2} state_t;
`endif

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATAWIDTH-1:0] word;
  logic [DATAWIDTH-1:0] word_nxt;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    logic [7:0] base;
    base = HEXUPPER ? 8'h41 : 8'h61;
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return base + {4'h0, n} - 8'd10;
  endfunction

  // The word is shifted left as nibbles go out, so the character being
  // emitted is always the top nibble; data_o is preloaded with the next
  // character one cycle ahead so it is stable for the whole push cycle.
  assign word_nxt = word << 4;

  // Push straight off full_i so a stall costs no extra cycle; reset gates it
  // so nothing leaks into the FIFO in the reset cycle.
  assign push_o = busy_o & ~full_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rdy_o  <= 1'b1;
      busy_o <= 1'b0;
      data_o <= 8'h00;
      cnt    <= '0;
      word   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stb_i) begin
            word   <= data_i;
            cnt    <= CNT_TOP;
            data_o <= to_ascii(data_i[DATAWIDTH-1 -: 4]);
            state  <= HEX;
            rdy_o  <= 1'b0;
            busy_o <= 1'b1;
          end
        end
        HEX: begin
          // full_i high: push_o is low, everything holds
          if (push_o) begin
            if (cnt == '0) begin
              state  <= SEP0;
              data_o <= SEP0_CH;
            end else begin
              cnt    <= cnt - 1'b1;
              word   <= word_nxt;
              data_o <= to_ascii(word_nxt[DATAWIDTH-1 -: 4]);
            end
          end
        end
        SEP0: begin
          if (push_o) begin
`ifdef UART_TX_HEXFMT_CRLF_EN
            state  <= SEP1;
            data_o <= SEP1_CH;
`else
            state  <= IDLE;
            rdy_o  <= 1'b1;
            busy_o <= 1'b0;
`endif
          end
        end
`ifdef UART_TX_HEXFMT_CRLF_EN
        SEP1: begin
          if (push_o) begin
            state  <= IDLE;
            rdy_o  <= 1'b1;
            busy_o <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          rdy_o  <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
